axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem.sv | 215 +++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI3-style burst slave backed by a word-addressed memory; independent
// read and write channels, each sequenced by its own three-process FSM.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | accepting awlen+1 write beats
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | presenting beats, one per rready cycle
module axi_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 256
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Wrap only for 2/4/8/16-beat bursts; other lengths fall back to INCR.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [3:0] len,
                                                 input logic [1:0] burst);
    logic [IDX_W-1:0] mask;
    mask = IDX_W'(len);
    case (burst)
      2'b00: next_idx = idx;
      2'b10: begin
        if (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)
          next_idx = (idx & ~mask) | ((idx + 1'b1) & mask);
        else
          next_idx = idx + 1'b1;
      end
      default: next_idx = idx + 1'b1;
    endcase
  endfunction

  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr, araddr};

  w_state_t w_state, w_next;
  logic [ID_WIDTH-1:0] w_id;
  logic [IDX_W-1:0]    w_idx;
  logic [3:0]          w_len, w_cnt;
  logic [1:0]          w_burst;
  logic                w_err;
  logic                aw_hs, w_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_cnt == 4'd0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE:  awready = !areset;
      W_DATA:  wready  = 1'b1;
      W_RESP:  bvalid  = 1'b1;
      default: ;
    endcase
  end

  // w_cnt counts beats still owed after the current one; zero marks the final beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= awid;
      w_idx   <= awaddr[LSB +: IDX_W];
      w_len   <= awlen;
      w_cnt   <= awlen;
      w_burst <= awburst;
      w_err   <= (awburst == 2'b11);
    end else if (w_hs) begin
      w_idx <= next_idx(w_idx, w_len, w_burst);
      w_cnt <= w_cnt - 1'b1;
      if (wlast != (w_cnt == 4'd0)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs)
      for (int i = 0; i < STRB_W; i++)
        if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
  end

  assign bid   = w_id;
  assign bresp = {w_err, 1'b0};

  r_state_t r_state, r_next;
  logic [ID_WIDTH-1:0] r_id;
  logic [IDX_W-1:0]    r_idx, ar_idx;
  logic [3:0]          r_len, r_cnt;
  logic [1:0]          r_burst;
  logic                r_err;
  logic                ar_hs, r_hs;

  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign ar_idx = araddr[LSB +: IDX_W];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_cnt == 4'd0) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (r_state)
      R_IDLE: arready = !areset;
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == 4'd0);
      end
      default: ;
    endcase
  end

  // rdata is fetched one beat ahead, so a same-cycle write is not visible.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      rdata   <= '0;
    end else if (ar_hs) begin
      r_id    <= arid;
      r_len   <= arlen;
      r_cnt   <= arlen;
      r_burst <= arburst;
      r_err   <= (arburst == 2'b11);
      rdata   <= mem[ar_idx];
      r_idx   <= next_idx(ar_idx, arlen, arburst);
    end else if (r_hs && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 1'b1;
      rdata <= mem[r_idx];
      r_idx <= next_idx(r_idx, r_len, r_burst);
    end
  end

  assign rid   = r_id;
  assign rresp = {r_err, 1'b0};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized bench for axi_slave_mem: a word-array model plus expected-beat
// queues, checked every negative clock edge, with a few literal anchors.
module tb_axi_slave_mem;
  localparam int DEPTH = 256;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial forever #5 aclk = ~aclk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic last; logic [1:0] resp; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

  logic [31:0] model_mem [DEPTH];
  r_exp_t      exp_r [$];
  b_exp_t      exp_b [$];
  logic [31:0] got_r [$];
  logic [3:0]  last_bid;
  logic [1:0]  last_bresp;
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  int          rready_mode = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Word touched by beat k, straight from the burst rules.
  function automatic int beat_idx(input int addr, input int len, input int burst, input int k);
    int start, n, base;
    start = (addr / 4) % DEPTH;
    n = len + 1;
    if (burst == 0) return start;
    if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
      base = start - (start % n);
      return base + ((start - base + k) % n);
    end
    return (start + k) % DEPTH;
  endfunction

  always @(negedge aclk) begin
    r_exp_t e;
    b_exp_t eb;
    if (!areset) begin
      if (rvalid) begin
        if (exp_r.size() == 0)
          check(1'b0, "r_unexpected", $sformatf("rvalid=1 data=%h, expected no beat", rdata));
        else begin
          e = exp_r[0];
          check(rdata === e.data && rid === e.id && rlast === e.last && rresp === e.resp, "r_beat",
                $sformatf("got id=%h data=%h last=%b resp=%h, expected id=%h data=%h last=%b resp=%h",
                          rid, rdata, rlast, rresp, e.id, e.data, e.last, e.resp));
          if (rready) begin
            got_r.push_back(rdata);
            void'(exp_r.pop_front());
          end
        end
      end
      if (bvalid) begin
        if (exp_b.size() == 0)
          check(1'b0, "b_unexpected", $sformatf("bvalid=1 bid=%h, expected no response", bid));
        else begin
          eb = exp_b[0];
          check(bid === eb.id && bresp === eb.resp, "b_resp",
                $sformatf("got bid=%h bresp=%h, expected bid=%h bresp=%h", bid, bresp, eb.id, eb.resp));
          if (bready) begin
            last_bid = bid;
            last_bresp = bresp;
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (rready_mode)
        0: rready = 1'b1;
        1: rready = !rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      bready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $fatal(1, "watchdog");
  end

  task automatic do_aw(input logic [3:0] id, input int addr, input int len, input int burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = 4'(len); awburst = 2'(burst); awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    check(awready === 1'b1, "aw_handshake", $sformatf("awready=%b after %0d cycles, expected 1", awready, n));
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input int idx);
    int n;
    n = $urandom_range(0, 2);
    if (n > 0) begin repeat (n) @(posedge aclk); #1; end
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!wready && n < 50) begin @(negedge aclk); n++; end
    check(wready === 1'b1, "w_handshake", $sformatf("wready=%b after %0d cycles, expected 1", wready, n));
    if (wready === 1'b1)
      for (int b = 0; b < 4; b++) if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wr_burst(input logic [3:0] id, input int addr, input int len, input int burst, input int bad);
    int n = 0;
    b_exp_t eb;
    eb.id = id;
    eb.resp = (burst == 3 || bad >= 0) ? 2'b10 : 2'b00;
    exp_b.push_back(eb);
    do_aw(id, addr, len, burst);
    for (int k = 0; k <= len; k++)
      w_beat(wbuf[k], sbuf[k], 1'((k == len) ^ (k == bad)), beat_idx(addr, len, burst, k));
    while (exp_b.size() != 0 && n < 100) begin @(negedge aclk); n++; end
    check(exp_b.size() == 0, "b_timeout", $sformatf("%0d responses outstanding, expected 0", exp_b.size()));
    exp_b.delete();
    @(posedge aclk); #1;
  endtask

  task automatic rd_burst(input logic [3:0] id, input int addr, input int len, input int burst);
    int n = 0;
    r_exp_t e;
    got_r.delete();
    arid = id; araddr = addr; arlen = 4'(len); arburst = 2'(burst); arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    check(arready === 1'b1, "ar_handshake", $sformatf("arready=%b after %0d cycles, expected 1", arready, n));
    if (arready === 1'b1)
      for (int k = 0; k <= len; k++) begin
        e.id = id;
        e.data = model_mem[beat_idx(addr, len, burst, k)];
        e.last = (k == len);
        e.resp = (burst == 3) ? 2'b10 : 2'b00;
        exp_r.push_back(e);
      end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    n = 0;
    while (exp_r.size() != 0 && n < 400) begin @(negedge aclk); n++; end
    check(exp_r.size() == 0, "r_timeout", $sformatf("%0d beats outstanding, expected 0", exp_r.size()));
    exp_r.delete();
    @(posedge aclk); #1;
  endtask

  task automatic check_got(input int i, input logic [31:0] exp, input string name);
    if (got_r.size() > i)
      check(got_r[i] === exp, name, $sformatf("beat %0d got %h, expected %h", i, got_r[i], exp));
    else
      check(1'b0, name, $sformatf("beat %0d missing (got %0d beats), expected %h", i, got_r.size(), exp));
  endtask

  task automatic check_reset_vals(input string name);
    check(awready === 0 && arready === 0 && wready === 0 && bvalid === 0 && rvalid === 0 &&
          rlast === 0 && bresp === 0 && rresp === 0 && bid === 0 && rid === 0 && rdata === 0, name,
          $sformatf("aw=%b ar=%b w=%b b=%b r=%b last=%b bresp=%h rresp=%h bid=%h rid=%h rdata=%h, expected all 0",
                    awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata));
  endtask

  initial begin
    int addr, len, burst, bad, sel;
    areset = 1'b1;
    awid = 0; awaddr = 0; awlen = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    arid = 0; araddr = 0; arlen = 0; arburst = 0; arvalid = 0;
    repeat (3) begin @(negedge aclk); check_reset_vals("reset_state"); end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check(awready === 1 && arready === 1, "release_ready",
          $sformatf("awready=%b arready=%b, expected 1 1", awready, arready));
    @(posedge aclk); #1;

    for (int blk = 0; blk < 16; blk++) begin
      for (int k = 0; k < 16; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
      wr_burst(4'(blk), blk * 64, 15, 1, -1);
    end

    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check(wready === 1'b0, "w_before_aw", $sformatf("wready=%b, expected 0", wready));
    end
    @(posedge aclk); #1;
    wvalid = 1'b0;

    for (int k = 0; k < 4; k++) begin wbuf[k] = 32'hA0 + k; sbuf[k] = 4'hF; end
    wr_burst(4'd5, 'h10, 3, 1, -1);
    check(last_bid === 4'd5 && last_bresp === 2'b00, "incr_write_resp",
          $sformatf("bid=%h bresp=%h, expected 5 0", last_bid, last_bresp));
    rd_burst(4'd6, 'h10, 3, 1);
    for (int k = 0; k < 4; k++) check_got(k, 32'hA0 + k, "incr_read");
    rd_burst(4'd7, 'h18, 3, 2);
    check_got(0, 32'hA2, "wrap_read");
    check_got(1, 32'hA3, "wrap_read");
    check_got(2, 32'hA0, "wrap_read");
    check_got(3, 32'hA1, "wrap_read");

    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'hF;
    wr_burst(4'd1, 'h40, 0, 1, -1);
    wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'b0101;
    wr_burst(4'd1, 'h40, 0, 1, -1);
    rd_burst(4'd2, 'h40, 0, 1);
    check_got(0, 32'h11BB_33DD, "partial_strobe");

    wbuf[0] = 32'h5A5A_0000; wbuf[1] = 32'h5A5A_0001; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    wr_burst(4'd9, 'h60, 1, 1, 1);
    check(last_bresp === 2'b10, "wlast_low_slverr", $sformatf("bresp=%h, expected 2", last_bresp));
    rready_mode = 1;
    rd_burst(4'd9, 'h60, 1, 1);
    check_got(0, 32'h5A5A_0000, "toggle_read");
    check_got(1, 32'h5A5A_0001, "toggle_read");
    rready_mode = 0;

    for (int k = 0; k < 8; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
    rready_mode = 2;
    fork
      wr_burst(4'd4, 'h200, 7, 1, -1);
      rd_burst(4'd3, 'h300, 7, 1);
    join
    rready_mode = 0;

    for (int k = 0; k < 4; k++) begin wbuf[k] = 32'hC0 + k; sbuf[k] = 4'hF; end
    do_aw(4'd3, 'h80, 3, 1);
    w_beat(wbuf[0], 4'hF, 1'b0, beat_idx('h80, 3, 1, 0));
    w_beat(wbuf[1], 4'hF, 1'b0, beat_idx('h80, 3, 1, 1));
    areset = 1'b1;
    repeat (2) begin @(negedge aclk); check_reset_vals("reset_mid_write"); end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check(awready === 1 && bvalid === 0 && wready === 0, "reset_release_mid",
          $sformatf("awready=%b bvalid=%b wready=%b, expected 1 0 0", awready, bvalid, wready));
    repeat (4) begin
      @(negedge aclk);
      check(bvalid === 1'b0, "no_b_after_abort", $sformatf("bvalid=%b, expected 0", bvalid));
    end
    @(posedge aclk); #1;
    rd_burst(4'd0, 'h80, 3, 1);
    check_got(0, 32'hC0, "abort_retained");
    check_got(1, 32'hC1, "abort_retained");

    for (int t = 0; t < 60; t++) begin
      addr = $urandom_range(0, 4095);
      len = $urandom_range(0, 15);
      sel = $urandom_range(0, 9);
      burst = (sel < 2) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
      if (burst == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'($urandom_range(0, 15)); end
        bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        wr_burst(4'($urandom_range(0, 15)), addr, len, burst, bad);
      end else begin
        rready_mode = $urandom_range(0, 2);
        rd_burst(4'($urandom_range(0, 15)), addr, len, burst);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
